// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter between the multicycle core and an external valid/ready master.
// The core has default priority; a starvation counter forces one external grant after MAX_WAIT refusals.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          ext_valid,
  output logic          ext_ready,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_adr,
  input  logic [DW-1:0] ext_wd,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [CW-1:0] stall_count
);

  localparam int             WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  // Handshake: an ext request is accepted in any cycle where ext_valid & ext_ready;
  // the master holds ext_* stable until then, and read data follows one cycle later with ext_rvalid.

  logic [WCW-1:0] r_wait_cnt;
  logic [DW-1:0]  r_ext_rdata;
  logic           r_ext_rvalid;
  logic [CW-1:0]  r_stall_count;

  logic w_force;
  logic w_g_ext;
  logic w_g_cpu;

  assign w_force = ext_valid & (r_wait_cnt == WAIT_MAX);
  assign w_g_ext = ext_valid & (~cpu_req | w_force);
  assign w_g_cpu = cpu_req & ~w_g_ext;

  assign ext_ready   = w_g_ext;
  assign cpu_stall   = cpu_req & w_g_ext;
  assign cpu_rd      = mem_rd;
  assign ext_rdata   = r_ext_rdata;
  assign ext_rvalid  = r_ext_rvalid;
  assign stall_count = r_stall_count;

  // With no owner the core address is still presented so its combinational read path stays live.
  always_comb begin
    mem_adr = cpu_adr;
    mem_wd  = cpu_wd;
    mem_we  = 1'b0;
    if (w_g_ext) begin
      mem_adr = ext_adr;
      mem_wd  = ext_wd;
      mem_we  = ext_we;
    end else if (w_g_cpu) begin
      mem_we  = cpu_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (w_g_ext || !ext_valid) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_rdata  <= '0;
      r_ext_rvalid <= 1'b0;
    end else if (w_g_ext && !ext_we) begin
      r_ext_rdata  <= mem_rd;
      r_ext_rvalid <= 1'b1;
    end else begin
      r_ext_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (cpu_stall && (r_stall_count != {CW{1'b1}})) begin
      r_stall_count <= r_stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them; a CW=2 copy checks stall_count saturation.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        ready;
    logic        stall;
    logic        mwe;
    logic        rvalid;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [15:0] sc;
    logic [1:0]  sc2;
  } exp_t;

  exp_t exp_q[$];

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ext_valid, ext_we;
  logic [31:0] cpu_adr, cpu_wd, ext_adr, ext_wd;
  logic [31:0] cpu_rd, ext_rdata, mem_adr, mem_wd, mem_rd;
  logic        cpu_stall, ext_ready, ext_rvalid, mem_we;
  logic [15:0] stall_count;

  logic [31:0] cpu_rd_2, ext_rdata_2, mem_adr_2, mem_wd_2;
  logic        cpu_stall_2, ext_ready_2, ext_rvalid_2, mem_we_2;
  logic [1:0]  stall_count_2;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_bad = 0;

  // driver-side model state
  logic        m_prev;
  logic [31:0] m_rd;
  logic [15:0] m_sc;
  logic [1:0]  m_sc2;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .CW(16)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_adr(ext_adr), .ext_wd(ext_wd), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stall_count(stall_count)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .CW(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd_2), .cpu_stall(cpu_stall_2),
    .ext_valid(ext_valid), .ext_ready(ext_ready_2), .ext_we(ext_we),
    .ext_adr(ext_adr), .ext_wd(ext_wd), .ext_rdata(ext_rdata_2), .ext_rvalid(ext_rvalid_2),
    .mem_we(mem_we_2), .mem_adr(mem_adr_2), .mem_wd(mem_wd_2), .mem_rd(mem_rd),
    .stall_count(stall_count_2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // combinational-read memory behind the port
  assign mem_rd = mem[mem_adr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr[7:2]] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ext_ready",     64'(ext_ready),     64'(e.ready));
      chk("cpu_stall",     64'(cpu_stall),     64'(e.stall));
      chk("mem_we",        64'(mem_we),        64'(e.mwe));
      chk("mem_adr",       64'(mem_adr),       64'(e.adr));
      chk("mem_wd",        64'(mem_wd),        64'(e.wd));
      chk("ext_rvalid",    64'(ext_rvalid),    64'(e.rvalid));
      chk("ext_rdata",     64'(ext_rdata),     64'(e.rdata));
      chk("stall_count",   64'(stall_count),   64'(e.sc));
      chk("stall_count_2", 64'(stall_count_2), 64'(e.sc2));
      chk("cpu_stall_2",   64'(cpu_stall_2),   64'(e.stall));
      chk("cpu_rd",        64'(cpu_rd),        64'(mem[mem_adr[7:2]]));
    end
  end

  // driver tasks
  task automatic cyc(input logic rst_v, input logic creq, input logic cwe,
                     input logic [31:0] cadr, input logic [31:0] cwd,
                     input logic ev, input logic ewe,
                     input logic [31:0] eadr, input logic [31:0] ewd,
                     input logic x_ready, input logic x_stall, input logic x_mwe,
                     input logic [31:0] x_adr, input logic [31:0] x_wd,
                     input logic [31:0] x_rdata);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v;
    cpu_req = creq; cpu_we = cwe; cpu_adr = cadr; cpu_wd = cwd;
    ext_valid = ev; ext_we = ewe; ext_adr = eadr; ext_wd = ewd;
    if (!rst_v) begin
      m_prev = 1'b0; m_rd = '0; m_sc = '0; m_sc2 = '0;
    end
    e.ready = x_ready; e.stall = x_stall; e.mwe = x_mwe;
    e.adr = x_adr; e.wd = x_wd; e.rvalid = m_prev; e.rdata = m_rd;
    e.sc = m_sc; e.sc2 = m_sc2;
    exp_q.push_back(e);
    if (rst_v) begin
      if (x_stall) begin
        if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (m_sc2 != 2'b11) m_sc2 = m_sc2 + 2'd1;
      end
      m_prev = x_ready & ev & ~ewe;
      if (m_prev) m_rd = x_rdata;
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rst_cycle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic cpu_only(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    cyc(1'b1, 1'b1, we, adr, wd, 1'b0, 1'b0, 32'h0, 32'h0,
        1'b0, 1'b0, we, adr, wd, 32'h0);
  endtask

  task automatic ext_only(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] rdata);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, adr, wd,
        1'b1, 1'b0, we, adr, wd, rdata);
  endtask

  // core reads 0x84, ext reads eadr; grant is the hand-computed arbitration outcome
  task automatic contend(input logic [31:0] eadr, input logic grant, input logic [31:0] rdata);
    cyc(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 1'b1, 1'b0, eadr, 32'h0,
        grant, grant, 1'b0, grant ? eadr : 32'h84, 32'h0, rdata);
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wd = 0;
    ext_valid = 0; ext_we = 0; ext_adr = 0; ext_wd = 0;
    m_prev = 0; m_rd = 0; m_sc = 0; m_sc2 = 0;

    rst_cycle();
    rst_cycle();
    idle();

    // core alone: never stalled, mem_we follows cpu_we
    for (int i = 0; i < 20; i++)
      cpu_only(i[0], 32'h80 + 32'(4 * i), 32'hA000_0000 + 32'(i));

    // ext write then read with the core idle
    ext_only(1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
    ext_only(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    idle();
    idle();

    // continuous contention: forced grant every 5th cycle, 10 grants total
    for (int i = 1; i <= 50; i++)
      contend(32'h40, (i % 5) == 0, 32'hDEADBEEF);
    cpu_only(1'b0, 32'h84, 32'h0);
    idle();

    // back-to-back ext accepts while the core is idle
    ext_only(1'b1, 32'h44, 32'h12345678, 32'h0);
    ext_only(1'b0, 32'h44, 32'h0, 32'h12345678);
    ext_only(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    idle();
    idle();

    // reset in the cycle after a read accept drops the pending rvalid
    ext_only(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    rst_cycle();
    idle();
    idle();

    // reset clears a partially counted wait: full MAX_WAIT refusals again afterwards
    for (int i = 1; i <= 3; i++) contend(32'h44, 1'b0, 32'h0);
    rst_cycle();
    for (int i = 1; i <= 5; i++) contend(32'h44, i == 5, 32'h12345678);
    idle();
    for (int i = 0; i < 4; i++) cpu_only(1'b1, 32'h90 + 32'(4 * i), 32'h5555_0000 + 32'(i));
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("expect_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
